shifter_seq_param: RTL and testbench
====================================

Name: shifter_seq_param

Overview:
Parametrised, registered universal shifter and the successor to the fixed 8-bit shifter.
- Adds width generics, a 3-bit mode set (logical, arithmetic, rotate, load, clear) and a serial fill input.
- Adds a multi-step sequencer that applies a shift-by-s n times, one step per clock, under a start/busy/done handshake.
- Sits in the datapath as a self-timed shift/rotate engine feeding downstream registers.

Parameters:
WIDTH, 8, data width (>=2)
SHW, 3, width of per-step shift amount s; must satisfy 2**SHW >= WIDTH
CNTW, 4, width of repeat count n

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
i  in  WIDTH  parallel load data
c  in  3  mode: 000 HOLD, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROL, 110 ROR, 111 CLR
s  in  SHW  shift amount per step
n  in  CNTW  number of steps for shift/rotate modes
sin  in  1  fill bit for SLL/SRL
start  in  1  operation request, sampled only in IDLE
o  out  WIDTH  registered result
busy  out  1  high while a multi-step operation runs
done  out  1  one-cycle completion pulse
cout  out  1  last bit shifted/rotated across the boundary

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst. On a rising edge with rst=1: o=0, cout=0, busy=0, done=0, step counter=0, state=IDLE. rst has priority over everything, including mid-operation.
- States: IDLE, RUN.
- IDLE, start=0: o, cout hold; done=0.
- IDLE, start=1 with an immediate op, or with a shift mode and n=0 (start sampled at edge T):
  - HOLD: o held.
  - LOAD: o=i.
  - CLR: o=0, cout=0.
  - Shift mode with n=0: o and cout unchanged.
  - Result visible after edge T; done=1 for the cycle after T; busy stays 0; state stays IDLE.
- IDLE, start=1 with a shift/rotate mode and n>0 (edge T):
  - Latch c, s, sin and n into internal registers; state=RUN, busy=1.
  - o is not modified at T.
- RUN: each edge applies one step using the latched mode and amount, then decrements the counter.
  - The edge applying step n (edge T+n) sets busy=0, done=1 and state=IDLE.
  - done is high for exactly the cycle after T+n; busy is high during cycles T..T+n-1.
  - Total latency start→done = n+1 edges.
- Inputs while busy: c, s, n, sin and start are ignored while busy=1. start asserted on the same edge that ends RUN is also ignored; a new start is accepted from the next IDLE edge.
- Step rules (k = s):
  - SLL: o = {o[WIDTH-1-k:0], k copies of sin}; cout = old o[WIDTH-k].
  - SRL: o = {k copies of sin, o[WIDTH-1:k]}; cout = old o[k-1].
  - SRA: as SRL but fill = old o[WIDTH-1]; cout = old o[k-1].
  - ROL/ROR: rotate by k mod WIDTH; cout = new o[0] (ROL) or new o[WIDTH-1] (ROR).
- Boundary conditions:
  - k=0: o and cout unchanged, but the step still counts.
  - k>=WIDTH (non-power-of-2 WIDTH): SLL/SRL give all-sin, SRA gives all-sign; cout = sin (SLL/SRL) or sign (SRA).
  - Counter wrap is impossible; n is latched once and only decremented to 0.

Decomposition:
- shifter_pkg holds the mode constants (MODE_HOLD .. MODE_CLR), the state encoding (ST_IDLE, ST_RUN) and a clog2 helper.
- One combinational sub-module, shift_step, takes (data, k, mode, sin) and returns (next_data, cout) for a single step. It is instantiated once.
- shifter_seq_param holds the FSM, the latched-operand registers, the counter and the output registers.

Test Plan (WIDTH=8):
1. rst for 2 edges, then LOAD with i=10101010 and start for one cycle → o=10101010 after the next edge; done=1 for one cycle; busy stays 0.
2. From o=10101010: SRA, s=2, n=1, start → busy=1 for one cycle, then o=11101010, cout=1; done pulses the following cycle.
3. From o=10101010: ROL, s=1, n=3 → o sequence 01010101, 10101010, 01010101; busy high 3 cycles; done after edge T+3; cout=1 after step 3.
4. From o=10101010: SLL, s=3, n=2, sin=1 → 01010111, then 10111111; cout=0 at end; change c and s to CLR during RUN → no effect.
5. ROR, s=1, n=5, start; re-assert start at cycle 2 → ignored; assert rst at cycle 3 → after that edge o=00000000, busy=0, done=0, state IDLE; no done pulse afterwards.
6. SRL, n=0, s=4, start → o unchanged, busy never high, done pulses one cycle; then CLR → o=0, cout=0.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared mode/state encodings and small helpers for the sequenced universal shifter.
package shifter_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SLL  = 3'b010,
    MODE_SRL  = 3'b011,
    MODE_SRA  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ROR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shifter_seq_param_if.sv
// Request/result bundle between a datapath controller (master) and the shifter (slave).
interface shifter_seq_param_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int CNTW  = 4
);
  logic [WIDTH-1:0] i;
  logic [2:0]       c;
  logic [SHW-1:0]   s;
  logic [CNTW-1:0]  n;
  logic             sin;
  logic             start;
  logic [WIDTH-1:0] o;
  logic             busy;
  logic             done;
  logic             cout;

  modport master (
    output i, c, s, n, sin, start,
    input  o, busy, done, cout
  );

  modport slave (
    input  i, c, s, n, sin, start,
    output o, busy, done, cout
  );
endinterface

// File: rtl/shift_step.sv
// Single combinational shift/rotate step; amounts at or beyond WIDTH saturate to pure fill.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   k_i,
  input  mode_e            mode_i,
  input  logic             sin_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] data_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] ones_s;
  logic [WIDTH-1:0] tmp_s;
  logic             fill_s;
  int unsigned      kk_s;
  int unsigned      r_s;

  assign ones_s = {WIDTH{1'b1}};

  // One step of the selected operation on the current register value
  always_comb begin
    data_o = data_i;
    cout_o = cin_i;
    tmp_s  = {WIDTH{1'b0}};
    kk_s   = 32'(k_i);
    r_s    = kk_s % 32'(WIDTH);
    fill_s = (mode_i == MODE_SRA) ? data_i[WIDTH-1] : sin_i;
    if (kk_s == 32'd0) begin
      data_o = data_i;
      cout_o = cin_i;
    end else begin
      case (mode_i)
        MODE_SLL: begin
          if (kk_s >= 32'(WIDTH)) begin
            data_o = {WIDTH{fill_s}};
            cout_o = fill_s;
          end else begin
            data_o = (data_i << kk_s) | (fill_s ? ~(ones_s << kk_s) : {WIDTH{1'b0}});
            tmp_s  = data_i >> (32'(WIDTH) - kk_s);
            cout_o = tmp_s[0];
          end
        end
        MODE_SRL, MODE_SRA: begin
          if (kk_s >= 32'(WIDTH)) begin
            data_o = {WIDTH{fill_s}};
            cout_o = fill_s;
          end else begin
            data_o = (data_i >> kk_s) | (fill_s ? ~(ones_s >> kk_s) : {WIDTH{1'b0}});
            tmp_s  = data_i >> (kk_s - 32'd1);
            cout_o = tmp_s[0];
          end
        end
        MODE_ROL: begin
          if (r_s == 32'd0) begin
            data_o = data_i;
          end else begin
            data_o = (data_i << r_s) | (data_i >> (32'(WIDTH) - r_s));
          end
          cout_o = data_o[0];
        end
        MODE_ROR: begin
          if (r_s == 32'd0) begin
            data_o = data_i;
          end else begin
            data_o = (data_i >> r_s) | (data_i << (32'(WIDTH) - r_s));
          end
          cout_o = data_o[WIDTH-1];
        end
        default: begin
          data_o = data_i;
          cout_o = cin_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_seq_param.sv
// Registered universal shifter with an n-step sequencer behind a start/busy/done handshake.
module shifter_seq_param
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int CNTW  = 4
) (
  input  logic                clk,
  input  logic                rst,
  shifter_seq_param_if.slave  bus
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  mode_e            mode_q, mode_d;
  logic [SHW-1:0]   amt_q, amt_d;
  logic             sin_q, sin_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] step_data_s;
  logic             step_cout_s;
  mode_e            req_mode_s;

  assign req_mode_s = mode_e'(bus.c);

  shift_step #(.WIDTH(WIDTH), .SHW(SHW)) u_step (
    .data_i (o_q),
    .k_i    (amt_q),
    .mode_i (mode_q),
    .sin_i  (sin_q),
    .cin_i  (cout_q),
    .data_o (step_data_s),
    .cout_o (step_cout_s)
  );

  // Next-state and output decode; only latched operands steer a running sequence
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    amt_d   = amt_q;
    sin_d   = sin_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (req_mode_s)
            MODE_HOLD: done_d = 1'b1;
            MODE_LOAD: begin
              o_d    = bus.i;
              done_d = 1'b1;
            end
            MODE_CLR: begin
              o_d    = {WIDTH{1'b0}};
              cout_d = 1'b0;
              done_d = 1'b1;
            end
            default: begin
              if (bus.n == {CNTW{1'b0}}) begin
                done_d = 1'b1;
              end else begin
                mode_d  = req_mode_s;
                amt_d   = bus.s;
                sin_d   = bus.sin;
                cnt_d   = bus.n;
                busy_d  = 1'b1;
                state_d = ST_RUN;
              end
            end
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      ST_RUN: begin
        o_d    = step_data_s;
        cout_d = step_cout_s;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      o_q     <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_HOLD;
      amt_q   <= {SHW{1'b0}};
      sin_q   <= 1'b0;
      cnt_q   <= {CNTW{1'b0}};
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      amt_q   <= amt_d;
      sin_q   <= sin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o    = o_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_shifter_seq_param.sv
// Directed bench for shifter_seq_param at WIDTH=8 with hand-computed expected values.
module tb_shifter_seq_param;
  import shifter_pkg::*;

  logic clk;
  logic rst;
  int   cmp_cnt;
  int   err_cnt;

  shifter_seq_param_if #(.WIDTH(8), .SHW(3), .CNTW(4)) bus ();

  shifter_seq_param #(.WIDTH(8), .SHW(3), .CNTW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [2:0] mode, input logic [2:0] amt, input logic [3:0] cnt,
                    input logic fill, input logic [7:0] data);
    bus.c     = mode;
    bus.s     = amt;
    bus.n     = cnt;
    bus.sin   = fill;
    bus.i     = data;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.c     = MODE_HOLD;
  endtask

  task automatic check_st(input string tag, input logic [7:0] o, input logic busy,
                          input logic done);
    check_val({tag, ".o"}, 32'(bus.o), 32'(o));
    check_val({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    check_val({tag, ".done"}, 32'(bus.done), 32'(done));
  endtask

  initial begin
    cmp_cnt   = 0;
    err_cnt   = 0;
    rst       = 1'b1;
    bus.i     = 8'h00;
    bus.c     = MODE_HOLD;
    bus.s     = 3'd0;
    bus.n     = 4'd0;
    bus.sin   = 1'b0;
    bus.start = 1'b0;
    tick();
    tick();
    check_st("rst", 8'h00, 1'b0, 1'b0);
    check_val("rst.cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;

    // 1: immediate load
    go(MODE_LOAD, 3'd0, 4'd0, 1'b0, 8'hAA);
    check_st("load", 8'hAA, 1'b0, 1'b1);
    tick();
    check_st("load.after", 8'hAA, 1'b0, 1'b0);

    // 2: SRA by 2, one step
    go(MODE_SRA, 3'd2, 4'd1, 1'b0, 8'h00);
    check_st("sra.T", 8'hAA, 1'b1, 1'b0);
    tick();
    check_st("sra.T1", 8'hEA, 1'b0, 1'b1);
    check_val("sra.cout", 32'(bus.cout), 32'd1);
    tick();
    check_st("sra.T2", 8'hEA, 1'b0, 1'b0);

    // 3: ROL by 1, three steps
    go(MODE_LOAD, 3'd0, 4'd0, 1'b0, 8'hAA);
    tick();
    go(MODE_ROL, 3'd1, 4'd3, 1'b0, 8'h00);
    check_st("rol.T", 8'hAA, 1'b1, 1'b0);
    tick();
    check_st("rol.s1", 8'h55, 1'b1, 1'b0);
    tick();
    check_st("rol.s2", 8'hAA, 1'b1, 1'b0);
    check_val("rol.cout2", 32'(bus.cout), 32'd0);
    tick();
    check_st("rol.s3", 8'h55, 1'b0, 1'b1);
    check_val("rol.cout3", 32'(bus.cout), 32'd1);

    // 4: SLL by 3 with sin=1; inputs and start while running are ignored
    go(MODE_LOAD, 3'd0, 4'd0, 1'b0, 8'hAA);
    tick();
    go(MODE_SLL, 3'd3, 4'd2, 1'b1, 8'h00);
    bus.c     = MODE_CLR;
    bus.s     = 3'd0;
    bus.start = 1'b1;
    tick();
    check_st("sll.s1", 8'h57, 1'b1, 1'b0);
    check_val("sll.cout1", 32'(bus.cout), 32'd1);
    tick();
    check_st("sll.s2", 8'hBF, 1'b0, 1'b1);
    check_val("sll.cout2", 32'(bus.cout), 32'd0);
    bus.start = 1'b0;
    bus.c     = MODE_HOLD;
    tick();
    check_st("sll.after", 8'hBF, 1'b0, 1'b0);

    // 5: ROR by 1, five steps, interrupted by reset
    go(MODE_LOAD, 3'd0, 4'd0, 1'b0, 8'h01);
    tick();
    go(MODE_ROR, 3'd1, 4'd5, 1'b0, 8'h00);
    tick();
    check_st("ror.s1", 8'h80, 1'b1, 1'b0);
    check_val("ror.cout1", 32'(bus.cout), 32'd1);
    bus.start = 1'b1;
    bus.c     = MODE_LOAD;
    bus.i     = 8'hFF;
    tick();
    check_st("ror.s2", 8'h40, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.c     = MODE_HOLD;
    rst       = 1'b1;
    tick();
    check_st("ror.rst", 8'h00, 1'b0, 1'b0);
    check_val("ror.rst.cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      check_st("ror.quiet", 8'h00, 1'b0, 1'b0);
    end

    // 6: n=0 leaves o/cout alone, then CLR
    go(MODE_LOAD, 3'd0, 4'd0, 1'b0, 8'hCC);
    tick();
    go(MODE_SRL, 3'd3, 4'd1, 1'b0, 8'h00);
    tick();
    check_st("srl3", 8'h19, 1'b0, 1'b1);
    check_val("srl3.cout", 32'(bus.cout), 32'd1);
    tick();
    go(MODE_SRL, 3'd4, 4'd0, 1'b1, 8'h00);
    check_st("srl.n0", 8'h19, 1'b0, 1'b1);
    check_val("srl.n0.cout", 32'(bus.cout), 32'd1);
    tick();
    check_st("srl.n0.after", 8'h19, 1'b0, 1'b0);
    go(MODE_CLR, 3'd0, 4'd0, 1'b0, 8'h00);
    check_st("clr", 8'h00, 1'b0, 1'b1);
    check_val("clr.cout", 32'(bus.cout), 32'd0);
    tick();

    // k=0 steps still count; HOLD completes immediately
    go(MODE_LOAD, 3'd0, 4'd0, 1'b0, 8'h5A);
    tick();
    go(MODE_SLL, 3'd0, 4'd2, 1'b1, 8'h00);
    check_st("k0.T", 8'h5A, 1'b1, 1'b0);
    tick();
    check_st("k0.s1", 8'h5A, 1'b1, 1'b0);
    tick();
    check_st("k0.s2", 8'h5A, 1'b0, 1'b1);
    tick();
    go(MODE_HOLD, 3'd0, 4'd0, 1'b0, 8'hFF);
    check_st("hold", 8'h5A, 1'b0, 1'b1);
    tick();

    // SRA by 7 from a negative value fills with sign bit
    go(MODE_LOAD, 3'd0, 4'd0, 1'b0, 8'h81);
    tick();
    go(MODE_SRA, 3'd7, 4'd1, 1'b0, 8'h00);
    tick();
    check_st("sra7", 8'hFF, 1'b0, 1'b1);
    check_val("sra7.cout", 32'(bus.cout), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
